// File: rtl/motor_ramp_pkg.sv
// Shared definitions for the motor ramp sequencer: register word indices,
// H-bridge ctrl encodings and the per-channel state enum.
package motor_ramp_pkg;

    // Register word indices (PADDR[4:2])
    localparam logic [2:0] REG_TGT1   = 3'd0;
    localparam logic [2:0] REG_TGT2   = 3'd1;
    localparam logic [2:0] REG_STEP   = 3'd2;
    localparam logic [2:0] REG_ESTOP  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam logic [1:0] CTRL_FWD   = 2'b10;
    localparam logic [1:0] CTRL_REV   = 2'b01;
    localparam logic [1:0] CTRL_COAST = 2'b00;

    typedef enum logic {
        RUN  = 1'b0,
        DEAD = 1'b1
    } chan_state_e;

endpackage

// File: rtl/motor_ramp_channel.sv
// One motor channel: ramps duty toward a signed target, with a coast period
// on direction reversal. All motion happens on tick; estop overrides.
module motor_ramp_channel
    import motor_ramp_pkg::*;
#(
    parameter int DUTY_W     = 18,
    parameter int DEAD_TICKS = 4
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              tick,
    input  logic              estop,
    input  logic [DUTY_W-1:0] step,
    input  logic [DUTY_W-1:0] tgt_mag,
    input  logic              tgt_rev,
    output logic [DUTY_W-1:0] duty,
    output logic [1:0]        ctrl,
    output logic              busy,
    output logic              in_dead
);
    localparam int CW = (DEAD_TICKS > 0) ? $clog2(DEAD_TICKS + 1) : 1;

    chan_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d, diff, delta;
    logic              dir_q, dir_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q <= RUN;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        diff    = (tgt_mag > duty_q) ? tgt_mag - duty_q : duty_q - tgt_mag;
        delta   = (step < diff) ? step : diff;
        if (estop) begin
            state_d = RUN;
            duty_d  = '0;
            dir_d   = 1'b0;
            cnt_d   = '0;
        end else if (tick) begin
            case (state_q)
                RUN: begin
                    if (dir_q != tgt_rev) begin
                        // Reversal: bleed duty off first, then coast before re-driving.
                        if (duty_q != '0)
                            duty_d = duty_q - ((step < duty_q) ? step : duty_q);
                        else if (tgt_mag != '0) begin
                            state_d = DEAD;
                            cnt_d   = CW'(DEAD_TICKS);
                        end else
                            dir_d = tgt_rev;
                    end else
                        duty_d = (tgt_mag > duty_q) ? duty_q + delta : duty_q - delta;
                end
                DEAD: begin
                    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
                    if (cnt_q <= CW'(1)) begin
                        state_d = RUN;
                        dir_d   = tgt_rev;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        in_dead = (state_q == DEAD);
        ctrl    = CTRL_COAST;
        if (!in_dead && duty_q != '0)
            ctrl = dir_q ? CTRL_REV : CTRL_FWD;
        busy = (duty_q != tgt_mag) || (dir_q != tgt_rev) || in_dead;
    end

    assign duty = duty_q;

endmodule

// File: rtl/motor_ramp_sequencer.sv
// APB3 motor ramp sequencer: register file, prescaler, ESTOP and two ramp channels.
// Optional target watchdog enabled by defining RAMP_WATCHDOG_EN.
module motor_ramp_sequencer
    import motor_ramp_pkg::*;
#(
    parameter int DUTY_W       = 18,
    parameter int DUTY_MAX     = 200000,
    parameter int RAMP_DIV     = 50000,
    parameter int DEFAULT_STEP = 1000,
    parameter int DEAD_TICKS   = 4
`ifdef RAMP_WATCHDOG_EN
    , parameter int WDOG_TICKS = 5000
`endif
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DUTY_W-1:0] motor1_duty,
    output logic [DUTY_W-1:0] motor2_duty,
    output logic [1:0]        motor1_ctrl,
    output logic [1:0]        motor2_ctrl,
    output logic              busy
);
    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [PW-1:0]     pre_q, pre_d;
    logic [DUTY_W-1:0] tgt1_q, tgt1_d, tgt2_q, tgt2_d, step_q, step_d, wmag;
    logic              rev1_q, rev1_d, rev2_q, rev2_d;
    logic              tick, acc, mapped, wr, estop, tgt_wr, wdog_trip;
    logic              busy1, busy2, dead1, dead2;
    logic [2:0]        idx;
    logic              unused_addr;

    assign unused_addr = &{1'b0, PADDR[31:5], PADDR[1:0]};

    assign idx     = PADDR[4:2];
    assign acc     = PSEL && PENABLE;
    assign mapped  = (idx <= REG_STATUS);
    assign PSLVERR = acc && (!mapped || (PWRITE && idx == REG_STATUS));
    assign wr      = acc && PWRITE && mapped && (idx != REG_STATUS);
    assign PREADY  = 1'b1;

    assign tick  = (pre_q == PW'(RAMP_DIV - 1));
    assign pre_d = tick ? '0 : pre_q + 1'b1;

    // The clamp looks at the full 31-bit magnitude so oversize values saturate instead of wrapping.
    assign wmag = (PWDATA[30:0] > 31'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : PWDATA[DUTY_W-1:0];

`ifdef RAMP_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_TICKS + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          trip_q, trip_d, wd_expire;

    assign wd_expire = tick && (wd_q == WW'(WDOG_TICKS - 1)) && !tgt_wr;
    assign wdog_trip = trip_q;

    always_comb begin
        wd_d   = wd_q;
        trip_d = trip_q;
        if (tgt_wr) begin
            wd_d   = '0;
            trip_d = 1'b0;
        end else if (tick && wd_q != WW'(WDOG_TICKS))
            wd_d = wd_q + 1'b1;
        if (wd_expire)
            trip_d = 1'b1;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wd_q   <= '0;
            trip_q <= 1'b0;
        end else begin
            wd_q   <= wd_d;
            trip_q <= trip_d;
        end
    end
`else
    logic unused_wd;
    assign unused_wd = tgt_wr;
    assign wdog_trip = 1'b0;
`endif

    always_comb begin
        tgt1_d = tgt1_q;
        rev1_d = rev1_q;
        tgt2_d = tgt2_q;
        rev2_d = rev2_q;
        step_d = step_q;
        estop  = 1'b0;
        tgt_wr = 1'b0;
`ifdef RAMP_WATCHDOG_EN
        if (wd_expire) begin
            tgt1_d = '0;
            tgt2_d = '0;
        end
`endif
        if (wr) begin
            case (idx)
                REG_TGT1:  begin tgt1_d = wmag; rev1_d = PWDATA[31]; tgt_wr = 1'b1; end
                REG_TGT2:  begin tgt2_d = wmag; rev2_d = PWDATA[31]; tgt_wr = 1'b1; end
                REG_STEP:  step_d = PWDATA[DUTY_W-1:0];
                REG_ESTOP: estop  = PWDATA[0];
                default:   ;
            endcase
        end
        if (estop) begin
            tgt1_d = '0;
            rev1_d = 1'b0;
            tgt2_d = '0;
            rev2_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            pre_q  <= '0;
            tgt1_q <= '0;
            rev1_q <= 1'b0;
            tgt2_q <= '0;
            rev2_q <= 1'b0;
            step_q <= DUTY_W'(DEFAULT_STEP);
        end else begin
            pre_q  <= pre_d;
            tgt1_q <= tgt1_d;
            rev1_q <= rev1_d;
            tgt2_q <= tgt2_d;
            rev2_q <= rev2_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        PRDATA = '0;
        if (acc && !PWRITE) begin
            case (idx)
                REG_TGT1:   begin PRDATA[DUTY_W-1:0] = tgt1_q; PRDATA[31] = rev1_q; end
                REG_TGT2:   begin PRDATA[DUTY_W-1:0] = tgt2_q; PRDATA[31] = rev2_q; end
                REG_STEP:   PRDATA[DUTY_W-1:0] = step_q;
                REG_STATUS: PRDATA[4:0] = {wdog_trip, dead2, dead1, busy2, busy1};
                default:    ;
            endcase
        end
    end

    motor_ramp_channel #(.DUTY_W(DUTY_W), .DEAD_TICKS(DEAD_TICKS)) u_ch1 (
        .PCLK(PCLK), .PRESET(PRESET), .tick(tick), .estop(estop), .step(step_q),
        .tgt_mag(tgt1_q), .tgt_rev(rev1_q), .duty(motor1_duty), .ctrl(motor1_ctrl),
        .busy(busy1), .in_dead(dead1)
    );

    motor_ramp_channel #(.DUTY_W(DUTY_W), .DEAD_TICKS(DEAD_TICKS)) u_ch2 (
        .PCLK(PCLK), .PRESET(PRESET), .tick(tick), .estop(estop), .step(step_q),
        .tgt_mag(tgt2_q), .tgt_rev(rev2_q), .duty(motor2_duty), .ctrl(motor2_ctrl),
        .busy(busy2), .in_dead(dead2)
    );

    assign busy = busy1 | busy2;

endmodule

// File: doc/motor_ramp_sequencer.md
# motor_ramp_sequencer

APB3 slave that sequences the two H-bridge motor channels of the car controller. Software writes a signed target speed per motor. The block ramps each channel's PWM duty toward that target at a programmed slew rate. On a direction reversal it ramps to zero, coasts for a fixed dead time, then re-drives in the new direction. It sits on a CoreAPB3 slot behind the MSS master and feeds duty/ctrl into the PWM stage that drives `motor*_pwm` / `motor*_ctrl`.

## Interface
Parameters:
- `DUTY_W`, 18, duty width in bits.
- `DUTY_MAX`, 200000, duty ceiling; equals the PWM period.
- `RAMP_DIV`, 50000, PCLK cycles per ramp tick.
- `DEFAULT_STEP`, 1000, reset value of STEP.
- `DEAD_TICKS`, 4, ramp ticks of coast on reversal.
- `WDOG_TICKS`, 5000, ramp ticks without a target write before fail-safe (macro only).

Ports (clock and reset first):
- `PCLK` in 1 — the block's one clock; fabric clock.
- `PRESET` in 1 — asynchronous, active-high reset.
- `PSEL` in 1 — APB select.
- `PENABLE` in 1 — APB enable.
- `PWRITE` in 1 — APB write.
- `PADDR` in 32 — byte address; only [4:2] decoded.
- `PWDATA` in 32 — write data.
- `PRDATA` out 32 — read data.
- `PREADY` out 1 — constant 1.
- `PSLVERR` out 1 — error response.
- `motor1_duty`, `motor2_duty` out DUTY_W — current duty per channel.
- `motor1_ctrl`, `motor2_ctrl` out 2 — 10 forward, 01 reverse, 00 coast.
- `busy` out 1 — any channel not yet settled at its target.

## Operation
- Register map (word offsets):
  - 0x00 TGT1, 0x04 TGT2: [DUTY_W-1:0] magnitude, [31] reverse. Magnitude above DUTY_MAX is clamped on write.
  - 0x08 STEP: [DUTY_W-1:0] duty change per tick. 0 freezes both ramps.
  - 0x0C ESTOP: write bit0=1 forces both targets and duties to 0 and ctrl to 00 on the next edge, with no ramp. Reads 0.
  - 0x10 STATUS (RO): [0] ch1 busy, [1] ch2 busy, [2] ch1 in DEAD, [3] ch2 in DEAD, [4] watchdog tripped.
- Unmapped offsets and writes to STATUS: PSLVERR=1 in the access phase. Writes are ignored; reads return 0.
- Prescaler: free-running 0..RAMP_DIV-1. `tick` pulses for one cycle at the terminal count.
- Per-channel FSM, evaluated only on `tick`:
  - RUN, direction differs from target and duty>0: duty -= min(STEP, duty).
  - RUN, direction differs from target, duty==0, target magnitude>0: go to DEAD and load the counter with DEAD_TICKS.
  - RUN, otherwise: duty moves toward the target magnitude by min(STEP, |diff|). A target of 0 adopts the target direction without entering DEAD.
  - DEAD: ctrl=00, counter decrements. At 0, the current direction takes the target direction and the FSM returns to RUN. Duty is still 0 at that point; the ramp resumes on the next tick.
- ctrl = 00 whenever duty==0 or the FSM is in DEAD; otherwise the direction encoding.
- A channel is busy when its duty differs from the target magnitude, its direction differs from the target direction, or it is in DEAD.
- Retargeting mid-ramp or mid-DEAD is legal. The next tick uses the new target. A DEAD period already started always completes.

## Timing
- APB has zero wait states. Registers update on the edge ending the access phase (PSEL&PENABLE&PWRITE).
- PRDATA is combinational during the access phase.
- Duty and ctrl change only on the edge that samples `tick` high, except ESTOP, which acts on the edge after the write.
- On reset, all outputs are 0 / 00 except PREADY=1. Both FSMs enter RUN, STEP=DEFAULT_STEP, and the prescaler and all counters clear.
- Reset asserted mid-ramp or mid-DEAD forces the reset state immediately, with no ramp down.

## Configuration
- `RAMP_WATCHDOG_EN` defined:
  - A tick counter is cleared by any TGT1/TGT2 write.
  - When it reaches WDOG_TICKS, both targets are set to 0 (a normal ramp down) and STATUS[4] is set.
  - STATUS[4] clears on the next target write.
  - A target write on the same cycle as expiry wins: the targets are taken from the write and the trip does not occur.
- Undefined: no watchdog; STATUS[4] reads 0.

## Structure
- Shared package `motor_ramp_pkg`: register offset constants, ctrl encodings (CTRL_FWD, CTRL_REV, CTRL_COAST), and the channel state enum (RUN, DEAD).
- Sub-module `motor_ramp_channel`: one FSM, duty register, direction register and dead counter. It is instantiated twice.
- The top level holds the APB decode, STEP, the prescaler, ESTOP and the watchdog.

## Test plan
All scenarios use RAMP_DIV=4, DEAD_TICKS=2, STEP written to 250.
- Write TGT1=1000 -> motor1_duty goes 250, 500, 750, 1000 on successive ticks (16 cycles). ctrl1=10 from the first nonzero duty; busy falls after the 4th tick.
- Write TGT1=0x80000000|500 from duty 1000 forward -> duty ramps down to 0 in 4 ticks, DEAD holds ctrl 00 for 2 ticks, then ctrl1=01 and duty ramps 250, 500.
- Write TGT2=300000 -> magnitude clamped to 200000; reads back 200000.
- Write ESTOP=1 mid-ramp -> both duties 0 and both ctrl 00 on the next edge; busy=0.
- Read offset 0x14 -> PSLVERR=1, PRDATA=0. Write STEP=0 mid-ramp -> duty holds its value across ticks.
- With `RAMP_WATCHDOG_EN` and WDOG_TICKS=8: no writes for 8 ticks -> targets become 0, duties ramp to 0, STATUS[4]=1. A TGT1 write then clears STATUS[4].
